// File: rtl/simple_clken_gen_pkg.sv
// Shared definitions for the lock-qualified clock-enable generator:
// FSM state encodings and a width helper for counters and channel indices.
package simple_clk_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_SETTLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  // Ceiling log2, never below 1 so single-entry indices stay legal vectors.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/simple_clken_gen_if.sv
// Control/status bundle of simple_clken_gen: PLL lock input, increment
// configuration port, and the lock/reset/enable outputs.
interface simple_clken_gen_if
  import simple_clk_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ACC_WIDTH = 24
) ();

  localparam int CH_W = clog2(NUM_CH);

  logic                 pll_locked;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [ACC_WIDTH-1:0] cfg_inc;
  logic                 cfg_sync;
  logic                 locked;
  logic                 sys_reset;
  logic [NUM_CH-1:0]    clken;

  modport master (
    output pll_locked, cfg_we, cfg_ch, cfg_inc, cfg_sync,
    input  locked, sys_reset, clken
  );

  modport slave (
    input  pll_locked, cfg_we, cfg_ch, cfg_inc, cfg_sync,
    output locked, sys_reset, clken
  );

endinterface

// File: rtl/simple_clken_gen_phase_acc.sv
// One fractional clock-enable channel: programmable increment, phase
// accumulator, and the accumulator carry registered as the enable pulse.
module clken_phase_acc #(
  parameter int                   ACC_WIDTH   = 24,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic                 sync_i,
  input  logic                 we_i,
  input  logic [ACC_WIDTH-1:0] inc_i,
  output logic                 clken_o
);

  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 clken_q, clken_d;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // Increments survive lock loss and sync; only reset restores the default.
  always_comb begin
    inc_d   = we_i ? inc_i : inc_q;
    acc_d   = '0;
    clken_d = 1'b0;
    if (run_i && !sync_i) begin
      acc_d   = sum[ACC_WIDTH-1:0];
      clken_d = sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q   <= DEFAULT_INC;
      acc_q   <= '0;
      clken_q <= 1'b0;
    end else begin
      inc_q   <= inc_d;
      acc_q   <= acc_d;
      clken_q <= clken_d;
    end
  end

  assign clken_o = clken_q;

endmodule

// File: rtl/simple_clken_gen.sv
// Holds downstream logic in reset until PLL lock has been stable long enough,
// then runs NUM_CH fractional clock-enable channels off the PLL clock.
module simple_clken_gen
  import simple_clk_pkg::*;
#(
  parameter int                   NUM_CH      = 4,
  parameter int                   ACC_WIDTH   = 24,
  parameter int                   LOCK_CYCLES = 1024,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}}
) (
  input  logic              refclk,
  input  logic              rst,
  simple_clken_gen_if.slave bus
);

  localparam int CH_W  = clog2(NUM_CH);
  localparam int CNT_W = clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic             sync1_q, lk_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, sys_reset_q;
  logic             run;
  logic [NUM_CH-1:0] clken;

  // pll_locked is asynchronous to refclk, so it crosses through two flops.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      lk_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_WAIT_LOCK: if (lk_s_q) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!lk_s_q)              state_d = ST_WAIT_LOCK;
        else if (cnt_q == CNT_LAST) state_d = ST_RUN;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN:       if (!lk_s_q) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      locked_q    <= (state_q == ST_RUN);
      sys_reset_q <= (state_q != ST_RUN);
    end
  end

  assign run = (state_q == ST_RUN);

  // Channel indices beyond NUM_CH match no instance, so such writes vanish.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clken_phase_acc #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DEFAULT_INC(DEFAULT_INC)
    ) u_acc (
      .clk    (refclk),
      .rst    (rst),
      .run_i  (run),
      .sync_i (bus.cfg_sync),
      .we_i   (bus.cfg_we && (bus.cfg_ch == CH_W'(c))),
      .inc_i  (bus.cfg_inc),
      .clken_o(clken[c])
    );
  end

  assign bus.locked    = locked_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.clken     = clken;

endmodule

// File: tb/tb_simple_clken_gen.sv
// Directed bench for simple_clken_gen: lock qualification, enable rates,
// lock loss, phase sync, and mid-run reset.
module tb_simple_clken_gen;

  localparam int NUM_CH       = 4;
  localparam int ACC_WIDTH    = 8;
  localparam int LOCK_CYCLES  = 16;
  localparam int LOCK_LATENCY = 2 + 1 + LOCK_CYCLES + 1;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   passCount  = 0;
  int   checkCount = 0;
  int   failCount  = 0;
  int   edges;
  int   seen;

  simple_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  simple_clken_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_WIDTH  (ACC_WIDTH),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] ch,
                               input logic [7:0] inc, input logic sync);
    bus.cfg_we   = we;
    bus.cfg_ch   = ch;
    bus.cfg_inc  = inc;
    bus.cfg_sync = sync;
    step();
    bus.cfg_we   = 1'b0;
    bus.cfg_sync = 1'b0;
  endtask

  // Returns the edge index (1-based) where locked first reads high, -1 if never.
  task automatic waitLocked(output int riseEdge);
    riseEdge = -1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (bus.locked === 1'b1) begin
        riseEdge = e;
        break;
      end
    end
  endtask

  // With increments 128/64/0/255, 256 steps return every accumulator to its
  // start value, so each channel pulses exactly inc times.
  task automatic measureRates(input string tag);
    int cnt[NUM_CH];
    int last[NUM_CH];
    int expCnt[NUM_CH] = '{128, 64, 0, 255};
    int expGap[2] = '{2, 4};
    int badGap = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c]  = 0;
      last[c] = -1;
    end
    for (int k = 0; k < 256; k++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.clken[c] === 1'b1) begin
          cnt[c]++;
          if (c < 2 && last[c] >= 0 && (k - last[c]) != expGap[c]) badGap++;
          last[c] = k;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      checkOutput($sformatf("%s pulses ch%0d", tag, c), cnt[c], expCnt[c]);
    checkOutput($sformatf("%s spacing ch0/ch1", tag), badGap, 0);
  endtask

  initial begin
    bus.pll_locked = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_inc    = '0;
    bus.cfg_sync   = 1'b0;

    // Held in reset with PLL already locked
    repeat (3) step();
    checkOutput("reset locked", bus.locked, 0);
    checkOutput("reset sys_reset", bus.sys_reset, 1);
    checkOutput("reset clken", bus.clken, 0);

    rst = 1'b0;
    waitLocked(edges);
    checkOutput("lock latency", edges, LOCK_LATENCY);
    checkOutput("sys_reset at lock", bus.sys_reset, 0);
    checkOutput("first step clken", bus.clken, 4'h0);

    applyStimulus(1'b1, 2'd1, 8'd64, 1'b0);
    checkOutput("second step clken", bus.clken, 4'hF);
    applyStimulus(1'b1, 2'd2, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'd3, 8'd255, 1'b0);
    measureRates("run");

    // Lock loss in RUN: two sync edges, one FSM edge, one output register edge
    bus.pll_locked = 1'b0;
    repeat (2) step();
    checkOutput("drop +2 locked", bus.locked, 1);
    repeat (2) step();
    checkOutput("drop +4 locked", bus.locked, 0);
    checkOutput("drop +4 sys_reset", bus.sys_reset, 1);
    checkOutput("drop +4 clken", bus.clken, 0);
    seen = 0;
    repeat (4) begin
      step();
      seen |= int'(bus.clken);
    end
    checkOutput("unlocked clken quiet", seen, 0);

    // Relock, then a one-cycle glitch at settle count 10 restarts the settle
    bus.pll_locked = 1'b1;
    seen = 0;
    repeat (13) begin
      step();
      seen |= int'(bus.locked);
    end
    bus.pll_locked = 1'b0;
    step();
    seen |= int'(bus.locked);
    bus.pll_locked = 1'b1;
    checkOutput("no lock during settle", seen, 0);
    waitLocked(edges);
    checkOutput("relock latency", edges, LOCK_LATENCY);
    checkOutput("relock first step", bus.clken, 4'h0);
    step();
    checkOutput("relock second step", bus.clken, 4'b1001);
    measureRates("relock");

    // Phase alignment: equal increments at unrelated phases
    applyStimulus(1'b1, 2'd0, 8'd64, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
    checkOutput("sync edge clken", bus.clken[1:0], 2'b00);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput($sformatf("aligned k%0d", k), bus.clken[1:0],
                  (k % 4 == 0) ? 2'b11 : 2'b00);
    end

    applyStimulus(1'b1, 2'd1, 8'd128, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput($sformatf("sync+we k%0d", k), bus.clken[1:0],
                  {(k % 2 == 0) ? 1'b1 : 1'b0, (k % 4 == 0) ? 1'b1 : 1'b0});
    end

    // Asynchronous reset pulse in RUN
    rst = 1'b1;
    #1;
    checkOutput("async rst locked", bus.locked, 0);
    checkOutput("async rst sys_reset", bus.sys_reset, 1);
    checkOutput("async rst clken", bus.clken, 0);
    step();
    rst = 1'b0;
    waitLocked(edges);
    checkOutput("post-reset lock latency", edges, LOCK_LATENCY);
    checkOutput("post-reset first step", bus.clken, 4'h0);
    step();
    checkOutput("post-reset default inc", bus.clken, 4'hF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
